// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: instruction memory port, hazard/redirect/halt controls
// and the IF/ID pipeline register outputs.
interface fetch_stage_if #(
  parameter int PC_W = 32
) ();
  logic [PC_W-1:0] instr_addr;
  logic [31:0]     instr_data;
  logic            stall;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            halt_req;
  logic            resume;
  logic [31:0]     if_id_instr;
  logic [PC_W-1:0] if_id_npc;
  logic            if_id_valid;
  logic            halted;
  logic [31:0]     fetch_count;

  modport master (
    output instr_addr, if_id_instr, if_id_npc, if_id_valid, halted, fetch_count,
    input  instr_data, stall, redirect_valid, redirect_pc, halt_req, resume
  );

  modport slave (
    input  instr_addr, if_id_instr, if_id_npc, if_id_valid, halted, fetch_count,
    output instr_data, stall, redirect_valid, redirect_pc, halt_req, resume
  );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction fetch: PC, IF/ID register, BOOT/RUN/HALT control.
// Optional retired-fetch counter enabled by FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              PC_INC    = 1,
  parameter logic [31:0]     NOP_INSTR = 32'h8000_0000
) (
  input  logic         clk,
  input  logic         rst,
  fetch_stage_if.master bus
);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] npc;
    logic            valid;
  } if_id_t;

  localparam if_id_t BUBBLE = '{instr: NOP_INSTR, npc: '0, valid: 1'b0};

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_nxt;
  if_id_t          if_id;
  logic            halted_q;

  // modulo 2^PC_W wrap comes for free from the truncating add
  assign pc_nxt = pc + PC_W'(PC_INC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      if_id    <= BUBBLE;
      halted_q <= 1'b0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (bus.redirect_valid) begin
            pc    <= bus.redirect_pc;
            if_id <= BUBBLE;
          end else if (bus.stall) begin
            // hold everything
          end else if (bus.halt_req) begin
            state    <= HALT;
            halted_q <= 1'b1;
            if_id    <= BUBBLE;
          end else begin
            if_id <= '{instr: bus.instr_data, npc: pc_nxt, valid: 1'b1};
            pc    <= pc_nxt;
          end
        end
        HALT: begin
          if (bus.redirect_valid) pc <= bus.redirect_pc;
          if (bus.resume) begin
            state    <= RUN;
            halted_q <= 1'b0;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

  assign bus.instr_addr  = pc;
  assign bus.if_id_instr = if_id.instr;
  assign bus.if_id_npc   = if_id.npc;
  assign bus.if_id_valid = if_id.valid;
  assign bus.halted      = halted_q;

`ifdef FETCH_PERF_CNT_EN
  logic        do_fetch;
  logic [31:0] fcnt;

  assign do_fetch = (state == RUN) && !bus.redirect_valid && !bus.stall && !bus.halt_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           fcnt <= '0;
    else if (do_fetch) fcnt <= fcnt + 32'd1;
  end

  assign bus.fetch_count = fcnt;
`else
  assign bus.fetch_count = 32'h0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory returns {16'hC0DE, addr[15:0]}.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   npass = 0;
  int   ntot  = 0;
  int   fexp  = 0;

  fetch_stage_if #(.PC_W(32)) bus ();

  fetch_stage #(.PC_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always_comb bus.instr_data = {16'hC0DE, bus.instr_addr[15:0]};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [31:0] npc,
                          input logic vld, input logic [31:0] addr);
    chk({tag, ".instr"}, 64'(bus.if_id_instr), 64'(ins));
    chk({tag, ".npc"},   64'(bus.if_id_npc),   64'(npc));
    chk({tag, ".valid"}, 64'(bus.if_id_valid), 64'(vld));
    chk({tag, ".addr"},  64'(bus.instr_addr),  64'(addr));
  endtask

  task automatic chk_cnt(input string tag);
`ifdef FETCH_PERF_CNT_EN
    chk(tag, 64'(bus.fetch_count), 64'(fexp));
`else
    chk(tag, 64'(bus.fetch_count), 64'd0);
`endif
  endtask

  task automatic redirect(input logic [31:0] tgt);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = tgt;
    step();
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    bus.stall = 0; bus.redirect_valid = 0; bus.redirect_pc = '0;
    bus.halt_req = 0; bus.resume = 0;

    // reset state
    #12;
    chk_ifid("rst", NOP, 0, 0, 0);
    chk("rst.halted", 64'(bus.halted), 64'd0);
    chk_cnt("rst.cnt");
    rst = 1'b0;

    // 1: BOOT edge then sequential fetch
    step(); chk_ifid("boot", NOP, 0, 0, 0);
    step(); chk_ifid("f0", 32'hC0DE_0000, 1, 1, 1);
    step(); chk_ifid("f1", 32'hC0DE_0001, 2, 1, 2);
    fexp = 2; chk_cnt("t1.cnt");

    // 2: stall holds pc and IF/ID
    redirect(4); chk_ifid("rd4", NOP, 0, 0, 4);
    step(); chk_ifid("f4", 32'hC0DE_0004, 5, 1, 5);
    fexp = 3;
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk_ifid("stall", 32'hC0DE_0004, 5, 1, 5);
    end
    chk_cnt("t2.cnt");
    bus.stall = 1'b0;
    step(); chk_ifid("f5", 32'hC0DE_0005, 6, 1, 6);
    fexp = 4;

    // 3: redirect beats stall
    redirect(9); chk_ifid("rd9", NOP, 0, 0, 9);
    bus.stall = 1'b1;
    redirect(20); chk_ifid("rd20", NOP, 0, 0, 20);
    bus.stall = 1'b0;
    step(); chk_ifid("f20", 32'hC0DE_0014, 21, 1, 21);
    fexp = 5; chk_cnt("t3.cnt");

    // 4: halt, redirect while halted, resume
    redirect(7);
    bus.halt_req = 1'b1;
    step(); chk_ifid("halt", NOP, 0, 0, 7);
    chk("halt.halted", 64'(bus.halted), 64'd1);
    bus.stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(); chk_ifid("halted", NOP, 0, 0, 7);
      chk("halted.flag", 64'(bus.halted), 64'd1);
    end
    bus.halt_req = 1'b0; bus.stall = 1'b0;
    redirect(3); chk_ifid("hrd3", NOP, 0, 0, 3);
    chk("hrd3.halted", 64'(bus.halted), 64'd1);
    bus.resume = 1'b1;
    step(); chk_ifid("resume", NOP, 0, 0, 3);
    chk("resume.halted", 64'(bus.halted), 64'd0);
    bus.resume = 1'b0;
    step(); chk_ifid("f3", 32'hC0DE_0003, 4, 1, 4);
    fexp = 6; chk_cnt("t4.cnt");

    // 5: pc wrap, then async reset mid-cycle
    redirect(32'hFFFF_FFFF); chk_ifid("rdmax", NOP, 0, 0, 32'hFFFF_FFFF);
    step(); chk_ifid("fmax", 32'hC0DE_FFFF, 0, 1, 0);
    step(); chk_ifid("fwrap", 32'hC0DE_0000, 1, 1, 1);
    fexp = 8; chk_cnt("t5.cnt");
    #2 rst = 1'b1;
    #1;
    chk_ifid("arst", NOP, 0, 0, 0);
    chk("arst.halted", 64'(bus.halted), 64'd0);
    fexp = 0; chk_cnt("arst.cnt");
    step(); chk_ifid("arst.hold", NOP, 0, 0, 0);
    rst = 1'b0;

    // 6: 10 fetches, 3 stalls, 1 redirect
    step(); chk_ifid("boot2", NOP, 0, 0, 0);
    for (int i = 0; i < 5; i++) step();
    chk_ifid("p5", 32'hC0DE_0004, 5, 1, 5);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) step();
    bus.stall = 1'b0;
    redirect(100);
    for (int i = 0; i < 5; i++) step();
    chk_ifid("p10", 32'hC0DE_0068, 105, 1, 105);
    fexp = 10; chk_cnt("t6.cnt");

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
